// File: rtl/uart_loader_pkg.sv
// Shared constants and state encodings for the UART host loader.
package uart_loader_pkg;

   localparam logic [7:0] SYNC  = 8'hA5;
   localparam logic [7:0] CMD_W = 8'h57;
   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] CMD_H = 8'h48;
   localparam logic [7:0] ACK   = 8'h06;
   localparam logic [7:0] NAK   = 8'h15;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   typedef enum logic [2:0] {P_IDLE, P_CMD, P_ADDR, P_DATA, P_STRB, P_SUM} p_state_t;

endpackage

// File: rtl/uart_host_loader_if.sv
// Host write port, core hold and response strobe driven by the loader.
interface uart_host_loader_if;

   logic        host_wvalid;
   logic [63:0] host_waddr;
   logic [63:0] host_wdata;
   logic [7:0]  host_wstrb;
   logic        core_hold;
   logic        ack_valid;
   logic [7:0]  ack_byte;
   logic        err_sticky;

   modport master (
      output host_wvalid, host_waddr, host_wdata, host_wstrb,
      output core_hold, ack_valid, ack_byte, err_sticky
   );

   modport slave (
      input host_wvalid, host_waddr, host_wdata, host_wstrb,
      input core_hold, ack_valid, ack_byte, err_sticky
   );

endinterface

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid strobe, framing-error strobe.
module uart_rx_8n1
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLK_HZ = 125_000_000,
   parameter int unsigned BAUD   = 115_200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic       valid,
   output logic [7:0] data,
   output logic       frame_err
);
   localparam int unsigned DIV       = CLK_HZ / BAUD;
   localparam logic [31:0] DIV_LAST  = 32'(DIV - 1);
   localparam logic [31:0] HALF_LAST = 32'(DIV / 2 - 1);

   rx_state_t   r_state, w_next;
   logic [1:0]  r_sync;
   logic [31:0] r_cnt;
   logic [2:0]  r_bit;
   logic [7:0]  r_shift;
   logic        r_valid, r_ferr;
   logic        w_rx, w_tick;

   assign w_rx = r_sync[1];

   // NOTE: state and data flops use <= so every flop updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RX_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: defaults first, so every path assigns w_next/w_tick and no latch is inferred.
   always_comb begin
      w_next = r_state;
      w_tick = 1'b0;
      case (r_state)
         RX_IDLE:  if (!w_rx) w_next = RX_START;
         RX_START: if (r_cnt == HALF_LAST) begin
            w_tick = 1'b1;
            w_next = w_rx ? RX_IDLE : RX_DATA;
         end
         RX_DATA:  if (r_cnt == DIV_LAST) begin
            w_tick = 1'b1;
            if (r_bit == 3'd7) w_next = RX_STOP;
         end
         RX_STOP:  if (r_cnt == DIV_LAST) begin
            w_tick = 1'b1;
            w_next = RX_IDLE;
         end
         default:  w_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sync flops reset to 1 so reset looks like an idle line, not a start bit.
         r_sync  <= 2'b11;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], rxd};
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         if (r_state == RX_IDLE || w_tick) r_cnt <= '0;
         else                              r_cnt <= r_cnt + 32'd1;
         if (r_state == RX_START && w_tick) r_bit <= '0;
         if (r_state == RX_DATA && w_tick) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
         end
         if (r_state == RX_STOP && w_tick) begin
            r_valid <= w_rx;
            r_ferr  <= !w_rx;
         end
      end
   end

   assign valid     = r_valid;
   assign data      = r_shift;
   assign frame_err = r_ferr;

endmodule

// File: rtl/uart_host_loader.sv
// UART-to-host-write bridge: parses A5/CMD/payload/SUM packets into host writes
// and core hold control, answering each packet with ACK or NAK.
module uart_host_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 125_000_000,
   parameter int unsigned BAUD        = 115_200,
   parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               uart_rx,
   uart_host_loader_if.master host
);
   localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYC);

   logic        w_rx_valid, w_rx_ferr;
   logic [7:0]  w_rx_data;
   p_state_t    r_pstate, w_pnext;
   logic        w_sum_ok, w_sum_bad, w_cmd_bad, w_timeout;
   logic [7:0]  r_cmd, r_sum, r_strb;
   logic [3:0]  r_idx;
   logic [31:0] r_addr, r_tmo;
   logic [63:0] r_data;
   logic        r_wvalid, r_hold, r_ack_valid, r_err;
   logic [63:0] r_waddr, r_wdata;
   logic [7:0]  r_wstrb, r_ack_byte;

   uart_rx_8n1 #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
      .clk      (clk),
      .rst_n    (rst_n),
      .rxd      (uart_rx),
      .valid    (w_rx_valid),
      .data     (w_rx_data),
      .frame_err(w_rx_ferr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pstate <= P_IDLE;
      else        r_pstate <= w_pnext;
   end

   always_comb begin
      w_pnext   = r_pstate;
      w_sum_ok  = 1'b0;
      w_sum_bad = 1'b0;
      w_cmd_bad = 1'b0;
      w_timeout = (r_pstate != P_IDLE) && !w_rx_valid && (r_tmo == TMO_LIM);
      if (w_rx_ferr || w_timeout) begin
         w_pnext = P_IDLE;
      end else if (w_rx_valid) begin
         case (r_pstate)
            P_IDLE: if (w_rx_data == SYNC) w_pnext = P_CMD;
            P_CMD: case (w_rx_data)
               CMD_W:        w_pnext = P_ADDR;
               CMD_G, CMD_H: w_pnext = P_SUM;
               default: begin
                  w_cmd_bad = 1'b1;
                  w_pnext   = P_IDLE;
               end
            endcase
            P_ADDR: if (r_idx == 4'd3) w_pnext = P_DATA;
            P_DATA: if (r_idx == 4'd7) w_pnext = P_STRB;
            P_STRB: w_pnext = P_SUM;
            P_SUM: begin
               w_pnext   = P_IDLE;
               w_sum_ok  = (w_rx_data == r_sum);
               w_sum_bad = (w_rx_data != r_sum);
            end
            default: w_pnext = P_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd       <= '0;
         r_sum       <= '0;
         r_strb      <= '0;
         r_idx       <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_tmo       <= '0;
         r_wvalid    <= 1'b0;
         r_waddr     <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_hold      <= 1'b1;
         r_ack_valid <= 1'b0;
         r_ack_byte  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_wvalid    <= 1'b0;
         r_ack_valid <= 1'b0;
         if (w_rx_ferr || w_timeout || w_sum_bad) r_err <= 1'b1;
         if (w_rx_valid || r_pstate == P_IDLE) r_tmo <= '0;
         else                                  r_tmo <= r_tmo + 32'd1;
         // Fields shift in from the top, so the first (least significant) byte ends up lowest.
         if (w_rx_valid) begin
            case (r_pstate)
               P_CMD: begin
                  r_cmd <= w_rx_data;
                  r_sum <= w_rx_data;
                  r_idx <= '0;
               end
               P_ADDR: begin
                  r_addr <= {w_rx_data, r_addr[31:8]};
                  r_sum  <= r_sum ^ w_rx_data;
                  r_idx  <= (r_idx == 4'd3) ? 4'd0 : r_idx + 4'd1;
               end
               P_DATA: begin
                  r_data <= {w_rx_data, r_data[63:8]};
                  r_sum  <= r_sum ^ w_rx_data;
                  r_idx  <= r_idx + 4'd1;
               end
               P_STRB: begin
                  r_strb <= w_rx_data;
                  r_sum  <= r_sum ^ w_rx_data;
               end
               default: ;
            endcase
         end
         if (w_sum_ok) begin
            r_ack_valid <= 1'b1;
            r_ack_byte  <= ACK;
            if (r_cmd == CMD_W) begin
               r_wvalid <= 1'b1;
               r_waddr  <= {32'd0, r_addr};
               r_wdata  <= r_data;
               r_wstrb  <= r_strb;
            end
            if (r_cmd == CMD_G) r_hold <= 1'b0;
            if (r_cmd == CMD_H) r_hold <= 1'b1;
         end
         if (w_sum_bad || w_cmd_bad) begin
            r_ack_valid <= 1'b1;
            r_ack_byte  <= NAK;
         end
      end
   end

   assign host.host_wvalid = r_wvalid;
   assign host.host_waddr  = r_waddr;
   assign host.host_wdata  = r_wdata;
   assign host.host_wstrb  = r_wstrb;
   assign host.core_hold   = r_hold;
   assign host.ack_valid   = r_ack_valid;
   assign host.ack_byte    = r_ack_byte;
   assign host.err_sticky  = r_err;

endmodule

// File: tb/tb_uart_host_loader.sv
// Bench for uart_host_loader: directed and random packets over the serial line,
// scored against a packet-level reference model.
module tb_uart_host_loader;

   localparam int DIV = 10;
   localparam logic [7:0] B_SYNC = 8'hA5;
   localparam logic [7:0] B_W    = 8'h57;
   localparam logic [7:0] B_G    = 8'h47;
   localparam logic [7:0] B_H    = 8'h48;
   localparam logic [7:0] B_ACK  = 8'h06;
   localparam logic [7:0] B_NAK  = 8'h15;

   typedef struct {
      logic [7:0] b;
      logic       hb;
      logic       ha;
      int         cyc;
   } ack_t;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      int          cyc;
   } wr_t;

   logic clk, rst_n, uart_rx;
   uart_host_loader_if bus ();

   uart_host_loader #(.CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_CYC(500)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .uart_rx(uart_rx),
      .host   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   n_wv_double = 0;
   logic prev_hold = 1'b1;
   logic prev_wv   = 1'b0;

   ack_t got_ack[$];
   ack_t exp_ack[$];
   wr_t  got_wr[$];
   wr_t  exp_wr[$];
   logic [7:0] pkt[$];
   logic m_hold, m_err;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst_n) begin
         if (bus.ack_valid)
            got_ack.push_back('{b: bus.ack_byte, hb: prev_hold, ha: bus.core_hold, cyc: cyc});
         if (bus.host_wvalid) begin
            got_wr.push_back('{addr: bus.host_waddr, data: bus.host_wdata, strb: bus.host_wstrb, cyc: cyc});
            if (prev_wv) n_wv_double = n_wv_double + 1;
         end
      end
      prev_hold = bus.core_hold;
      prev_wv   = bus.host_wvalid;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx = stop;
      repeat (DIV) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic send_raw(input int gap_max);
      foreach (pkt[i]) begin
         send_byte(pkt[i], 1'b1);
         repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
   endtask

   task automatic build_w(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input logic [7:0] corrupt);
      logic [7:0] sum;
      pkt.delete();
      pkt.push_back(B_SYNC);
      pkt.push_back(B_W);
      for (int i = 0; i < 4; i++) pkt.push_back(a[8*i +: 8]);
      for (int i = 0; i < 8; i++) pkt.push_back(d[8*i +: 8]);
      pkt.push_back(s);
      sum = 8'h00;
      for (int i = 1; i < pkt.size(); i++) sum = sum ^ pkt[i];
      pkt.push_back(sum ^ corrupt);
   endtask

   task automatic build_gh(input logic [7:0] cmd, input logic [7:0] corrupt);
      pkt.delete();
      pkt.push_back(B_SYNC);
      pkt.push_back(cmd);
      pkt.push_back(cmd ^ corrupt);
   endtask

   // Packet-level reference: decide the outcome of a complete packet from its bytes.
   task automatic model_pkt();
      logic [7:0]  cmd, sum;
      logic [63:0] d;
      logic        old;
      cmd = pkt[1];
      old = m_hold;
      if (cmd != B_W && cmd != B_G && cmd != B_H) begin
         exp_ack.push_back('{b: B_NAK, hb: old, ha: old, cyc: 0});
         return;
      end
      sum = 8'h00;
      for (int i = 1; i < pkt.size() - 1; i++) sum = sum ^ pkt[i];
      if (sum != pkt[pkt.size() - 1]) begin
         m_err = 1'b1;
         exp_ack.push_back('{b: B_NAK, hb: old, ha: old, cyc: 0});
         return;
      end
      if (cmd == B_G) m_hold = 1'b0;
      if (cmd == B_H) m_hold = 1'b1;
      if (cmd == B_W) begin
         d = 64'd0;
         for (int i = 0; i < 8; i++) d = d | (64'(pkt[6 + i]) << (8 * i));
         exp_wr.push_back('{addr: {32'd0, pkt[5], pkt[4], pkt[3], pkt[2]}, data: d,
                            strb: pkt[14], cyc: 0});
      end
      exp_ack.push_back('{b: B_ACK, hb: old, ha: m_hold, cyc: 0});
   endtask

   task automatic compare_events(input string tag);
      check({tag, " n_ack"}, 64'(got_ack.size()), 64'(exp_ack.size()));
      for (int i = 0; i < got_ack.size() && i < exp_ack.size(); i++) begin
         check({tag, " ack_byte"}, 64'(got_ack[i].b), 64'(exp_ack[i].b));
         check({tag, " hold_before_ack"}, 64'(got_ack[i].hb), 64'(exp_ack[i].hb));
         check({tag, " hold_at_ack"}, 64'(got_ack[i].ha), 64'(exp_ack[i].ha));
      end
      check({tag, " n_write"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++) begin
         check({tag, " waddr"}, got_wr[i].addr, exp_wr[i].addr);
         check({tag, " wdata"}, got_wr[i].data, exp_wr[i].data);
         check({tag, " wstrb"}, 64'(got_wr[i].strb), 64'(exp_wr[i].strb));
         if (got_ack.size() > 0)
            check({tag, " write_with_ack_cycle"}, 64'(got_wr[i].cyc), 64'(got_ack[0].cyc));
      end
      check({tag, " err_sticky"}, 64'(bus.err_sticky), 64'(m_err));
      check({tag, " core_hold"}, 64'(bus.core_hold), 64'(m_hold));
      got_ack.delete();
      exp_ack.delete();
      got_wr.delete();
      exp_wr.delete();
   endtask

   task automatic send_pkt(input int gap_max, input string tag);
      send_raw(gap_max);
      model_pkt();
      repeat (10) @(negedge clk);
      compare_events(tag);
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      check("rst core_hold", 64'(bus.core_hold), 64'd1);
      check("rst host_wvalid", 64'(bus.host_wvalid), 64'd0);
      check("rst host_waddr", bus.host_waddr, 64'd0);
      check("rst host_wdata", bus.host_wdata, 64'd0);
      check("rst host_wstrb", 64'(bus.host_wstrb), 64'd0);
      check("rst ack_valid", 64'(bus.ack_valid), 64'd0);
      check("rst ack_byte", 64'(bus.ack_byte), 64'd0);
      check("rst err_sticky", 64'(bus.err_sticky), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      got_ack.delete();
      exp_ack.delete();
      got_wr.delete();
      exp_wr.delete();
      m_hold = 1'b1;
      m_err  = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s, c, corrupt;
      int          kind;

      rst_n   = 1'b0;
      uart_rx = 1'b1;
      m_hold  = 1'b1;
      m_err   = 1'b0;
      do_reset();

      build_w(32'h0001_0000, 64'h1122_3344_5566_7788, 8'hFF, 8'h00);
      send_pkt(0, "write");
      check("write field waddr", bus.host_waddr, 64'h0000_0000_0001_0000);
      check("write field wdata", bus.host_wdata, 64'h1122_3344_5566_7788);
      check("write field wstrb", 64'(bus.host_wstrb), 64'hFF);

      build_gh(B_G, 8'h00);
      send_pkt(0, "go");
      build_gh(B_H, 8'h00);
      send_pkt(0, "halt");

      build_w(32'hDEAD_BEE0, 64'h0102_0304_0506_0708, 8'h0F, 8'h01);
      send_pkt(0, "badsum");
      check("badsum wdata kept", bus.host_wdata, 64'h1122_3344_5566_7788);

      // A short low pulse on an idle line must not start a byte.
      do_reset();
      uart_rx = 1'b0;
      repeat (3) @(negedge clk);
      uart_rx = 1'b1;
      repeat (200) @(negedge clk);
      compare_events("glitch");

      pkt.delete();
      pkt.push_back(B_SYNC);
      pkt.push_back(B_W);
      send_raw(0);
      send_byte(8'h00, 1'b0);
      m_err = 1'b1;
      repeat (20) @(negedge clk);
      compare_events("framing");
      build_gh(B_G, 8'h00);
      send_pkt(0, "after_framing");

      do_reset();
      pkt.delete();
      pkt.push_back(B_SYNC);
      pkt.push_back(B_W);
      pkt.push_back(8'h00);
      send_raw(0);
      repeat (600) @(negedge clk);
      m_err = 1'b1;
      compare_events("timeout");
      build_gh(B_G, 8'h00);
      send_pkt(0, "after_timeout");

      do_reset();
      build_gh(B_G, 8'h00);
      send_pkt(0, "pre_reset_go");
      build_w(32'h0000_4000, 64'hCAFE_F00D_1234_5678, 8'hF0, 8'h00);
      pkt = pkt[0:7];
      send_raw(0);
      uart_rx = 1'b0;
      repeat (25) @(negedge clk);
      do_reset();
      repeat (50) @(negedge clk);
      compare_events("mid_reset");
      build_w(32'h0000_4000, 64'hCAFE_F00D_1234_5678, 8'hF0, 8'h00);
      send_pkt(0, "post_reset_write");

      do_reset();
      for (int n = 0; n < 16; n++) begin
         kind    = int'($urandom_range(0, 9));
         corrupt = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
         if (kind < 5) begin
            a = $urandom;
            d = {$urandom, $urandom};
            s = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            build_w(a, d, s, corrupt);
         end else if (kind < 7) begin
            build_gh(B_G, corrupt);
         end else if (kind < 9) begin
            build_gh(B_H, corrupt);
         end else begin
            c = 8'($urandom);
            while (c == B_W || c == B_G || c == B_H) c = 8'($urandom);
            pkt.delete();
            pkt.push_back(B_SYNC);
            pkt.push_back(c);
         end
         send_pkt(30, "random");
      end

      check("wvalid single cycle", 64'(n_wv_double), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_host_loader.md
# uart_host_loader

UART-to-host-write bridge that sits upstream of the LinxISA core on the Zybo bring-up top. It receives 8N1 serial frames, parses a small checksummed command protocol, drives the core's `host_wvalid/host_waddr/host_wdata/host_wstrb` write port, and holds or releases the core via `core_hold`. The top ORs `core_hold` into the core reset and may route `ack_valid/ack_byte` into the existing UART TX FIFO.

## Interface
- `CLK_HZ`, default 125_000_000: clock frequency.
- `BAUD`, default 115_200: line rate. `DIV = CLK_HZ/BAUD`, truncated; 1085 at the defaults.
- `TIMEOUT_CYC`, default 2_000_000: maximum idle cycles between bytes inside a packet.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `uart_rx` input 1: raw serial input, asynchronous.
- `host_wvalid` output 1: one-cycle write strobe.
- `host_waddr` output 64: write byte address.
- `host_wdata` output 64: write data.
- `host_wstrb` output 8: byte enables.
- `core_hold` output 1: 1 holds the core in reset.
- `ack_valid` output 1: one-cycle response strobe.
- `ack_byte` output 8: response byte. 0x06 means ACK; 0x15 means NAK.
- `err_sticky` output 1: framing, checksum or timeout error seen since reset.

## Operation
- Reset values:
  - `core_hold` = 1.
  - All other outputs are 0.
  - Synchronizer flops reset to 1 (idle line).
- RX path:
  - `uart_rx` passes through a 2FF synchronizer.
  - States IDLE, START, DATA, STOP.
  - IDLE → START on a synced low.
  - START waits DIV/2 cycles, then resamples. Low → DATA. High → IDLE (glitch, no error).
  - DATA samples 8 bits LSB-first, one every DIV cycles.
  - STOP samples after DIV cycles. High → `rx_valid` pulses one cycle with the byte. Low → framing error: byte dropped, `err_sticky` set, parser reset to P_IDLE.
  - The RX FSM returns to IDLE immediately after the stop sample.
- Packet format, all multi-byte fields little-endian: `0xA5, CMD, payload, SUM`. `SUM` is the XOR of CMD and all payload bytes.
- Commands:
  - `W` (0x57): payload is ADDR[31:0] (4 bytes), DATA (8 bytes), STRB (1 byte). Address is zero-extended to 64 bits.
  - `G` (0x47): go, no payload. Clears `core_hold`.
  - `H` (0x48): halt, no payload. Sets `core_hold`.
- Parser FSM: P_IDLE, P_CMD, P_ADDR, P_DATA, P_STRB, P_SUM. A 4-bit byte index counts within the ADDR and DATA fields.
  - P_IDLE discards every byte except 0xA5.
  - In P_CMD, an unknown CMD gives a NAK and returns to P_IDLE.
  - In P_CMD, a G or H byte jumps straight to P_SUM.
- Execute, on a SUM byte:
  - SUM matches, cmd W: assemble `host_waddr/host_wdata/host_wstrb` and pulse `host_wvalid`. The three fields stay stable until the next W execute.
  - SUM matches, cmd G or H: update `core_hold`.
  - Every matching SUM also produces ACK.
  - SUM mismatch: no write and no hold change, NAK, `err_sticky` set.
- Timeout: in any state other than P_IDLE, a counter counts cycles since the last `rx_valid`. When it reaches TIMEOUT_CYC the parser returns to P_IDLE, `err_sticky` is set, and no ACK/NAK is sent.
- A W packet with STRB = 0 still pulses `host_wvalid`; the core ignores it.
- `host_wvalid` is a single-cycle pulse. The core has no backpressure.

## Timing
- On SUM validation, `host_wvalid`, `ack_valid` and the `core_hold` change are all registered. They appear in the cycle after the `rx_valid` for the SUM byte.
- One byte takes 10·DIV cycles; back-to-back bytes with no idle gap are supported.
- The earliest next packet is one byte-time after the SUM byte, so consecutive `host_wvalid` pulses are at least 10·DIV cycles apart.
- Asynchronous reset mid-byte or mid-packet aborts all state, with no partial write. `core_hold` returns to 1.

## Structure
- Shared package `uart_loader_pkg`:
  - Constants SYNC = 0xA5, CMD_W, CMD_G, CMD_H, ACK = 0x06, NAK = 0x15.
  - Enums for the RX and parser states.
- Sub-module `uart_rx_8n1`: parameters CLK_HZ and BAUD; ports `clk`, `rst_n`, `rxd`, `valid`, `data[7:0]`, `frame_err`. It mirrors the existing TX.
- The parser, checksum and timeout logic live in the top of this block.

## Test plan
All scenarios use CLK_HZ=1_000_000, BAUD=100_000 (DIV=10), TIMEOUT_CYC=500.
- Write packet: send A5 57 00 00 01 00 88 77 66 55 44 33 22 11 FF and a correct SUM.
  - One `host_wvalid` pulse with `host_waddr`=0x10000, `host_wdata`=0x1122334455667788, `host_wstrb`=0xFF.
  - ACK 0x06; `core_hold` still 1.
- Go then halt: send A5 47 47.
  - `core_hold` drops to 0 the cycle after the last byte's `rx_valid`; ACK.
  - Then send A5 48 48: `core_hold` returns to 1.
- Bad checksum: send a W packet whose SUM is XOR^0x01.
  - No `host_wvalid`; NAK 0x15; `err_sticky`=1.
- Framing and glitch:
  - A byte with stop bit = 0 gives no `rx_valid` and sets `err_sticky`.
  - A 3-cycle low glitch on an idle line produces no byte.
- Timeout: send A5 57 00, then idle 600 cycles, then a valid G packet.
  - `err_sticky`=1, no NAK for the aborted packet.
  - The G packet is accepted (ACK, `core_hold`=0).
- Reset mid-packet: assert `rst_n`=0 during the DATA bytes of a W packet.
  - All outputs return to reset values and `core_hold`=1.
  - A following full W packet executes normally.
